// File: rtl/mv_vector_stream_io.sv
// Streaming wrapper for the systolic matrix-vector multiplier: assembles an input
// element stream into a parallel vector, waits the compute latency, streams the result.
module mv_vector_stream_io #(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 64,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic [SIZE*WIDTH-1:0]   vec_out,
  input  logic [SIZE*WIDTH-1:0]   vec_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_len,
  output logic [1:0]              o_dbg_state
);

  // Both streams use plain valid/ready: a transfer happens on every rising edge
  // where valid && ready; data and last are stable whenever valid is high and
  // ready is low. s_ready/m_valid are pure functions of state (and rst).

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);
  localparam logic [7:0]    CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STREAM  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_oidx;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic [WIDTH-1:0]      r_buf [SIZE];
  logic [WIDTH-1:0]      r_res [SIZE];
  logic [SIZE*WIDTH-1:0] r_vec_out;
  logic [SIZE*WIDTH-1:0] w_launch_vec;

  logic w_s_fire;
  logic w_m_fire;
  logic w_launch;
  logic w_len_err;
  logic w_m_done;

  assign w_s_fire  = s_valid && s_ready;
  assign w_m_fire  = m_valid && m_ready;
  assign w_launch  = w_s_fire && (s_last || (r_idx == LAST_IDX));
  assign w_len_err = w_s_fire && (s_last != (r_idx == LAST_IDX));
  assign w_m_done  = w_m_fire && (r_oidx == LAST_IDX);

  // Launch image: loaded elements, the element arriving now, zeros beyond it.
  always_comb begin
    w_launch_vec = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (IW'(i) < r_idx) begin
        w_launch_vec[i*WIDTH +: WIDTH] = r_buf[i];
      end else if (IW'(i) == r_idx) begin
        w_launch_vec[i*WIDTH +: WIDTH] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD:    if (w_launch) w_next_state = ST_WAIT;
      ST_WAIT:    if (r_cnt == 8'd0) w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_STREAM;
      ST_STREAM:  if (w_m_done) w_next_state = ST_LOAD;
      default:    w_next_state = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    busy    = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_LOAD: s_ready = 1'b1;
        ST_STREAM: begin
          m_valid = 1'b1;
          m_last  = (r_oidx == LAST_IDX);
          busy    = 1'b1;
        end
        default: busy = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_oidx    <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_vec_out <= '0;
      for (int i = 0; i < SIZE; i++) begin
        r_buf[i] <= '0;
        r_res[i] <= '0;
      end
    end else begin
      r_err <= w_len_err;
      if (w_s_fire) begin
        r_buf[r_idx] <= s_data;
        if (w_launch) begin
          r_vec_out <= w_launch_vec;
          r_idx     <= '0;
          r_cnt     <= CNT_INIT;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (r_state == ST_WAIT && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == ST_CAPTURE) begin
        for (int i = 0; i < SIZE; i++) begin
          r_res[i] <= vec_in[i*WIDTH +: WIDTH];
        end
        r_oidx <= '0;
      end
      if (w_m_fire) begin
        r_oidx <= w_m_done ? '0 : r_oidx + 1'b1;
      end
    end
  end

  assign vec_out     = r_vec_out;
  assign m_data      = r_res[r_oidx];
  assign err_len     = r_err && !rst;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mv_vector_stream_io.sv
// Directed bench for mv_vector_stream_io: a SIZE=4/LATENCY=2 instance looped back
// on itself and a default-size instance whose result is the negated input.
module tb_mv_vector_stream_io;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic           s_valid, s_ready, s_last, m_valid, m_ready, m_last, busy, err_len;
  logic [W-1:0]   s_data, m_data;
  logic [4*W-1:0] vec_out, vec_in;
  logic [1:0]     dbg_state;

  logic            b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
  logic            b_busy, b_err_len;
  logic [W-1:0]    b_s_data, b_m_data;
  logic [64*W-1:0] b_vec_out, b_vec_in;
  logic [1:0]      b_dbg_state;

  assign vec_in = vec_out;

  for (genvar g = 0; g < 64; g++) begin : g_neg
    assign b_vec_in[g*W +: W] = ~b_vec_out[g*W +: W] + 1'b1;
  end

  mv_vector_stream_io #(.WIDTH(W), .SIZE(4), .LATENCY(2)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .vec_out(vec_out), .vec_in(vec_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_len(err_len), .o_dbg_state(dbg_state)
  );

  mv_vector_stream_io #(.WIDTH(W)) u_dut64 (
    .clk(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
    .vec_out(b_vec_out), .vec_in(b_vec_in),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .busy(b_busy), .err_len(b_err_len), .o_dbg_state(b_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) if (err_len) err_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n elements of v into the small instance; s_last on the final one if asked.
  task automatic send4(input logic [W-1:0] v [4], input int n, input bit last_final,
                       input bit exp_err, input string tag);
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      s_valid = 1'b1;
      s_data  = v[i];
      s_last  = last_final && (i == n - 1);
      while (!s_ready && cyc < 50) begin
        tick();
        cyc++;
      end
      if (!s_ready) check({tag, " s_ready timeout"}, 64'(s_ready), 64'd1);
      tick();
      check({tag, " err_len"}, 64'(err_len), 64'(exp_err && (i == n - 1)));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Collects n results from the small instance, comparing against exp_q.
  task automatic drain(input int n, input bit bp, input string tag);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] e;
    while (got < n && cyc < 200) begin
      m_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (stalled) check({tag, " hold"}, 64'(m_data), 64'(held));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, " queue empty"}, 64'(exp_q.size()), 64'd1);
          e = '0;
        end else begin
          e = exp_q.pop_front();
        end
        check({tag, " data"}, 64'(m_data), 64'(e));
        check({tag, " last"}, 64'(m_last), 64'(got == n - 1));
        check({tag, " s_ready low"}, 64'(s_ready), 64'd0);
        got++;
        stalled = 1'b0;
      end else if (m_valid) begin
        stalled = 1'b1;
        held = m_data;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    check({tag, " count"}, 64'(got), 64'(n));
    check({tag, " m_valid idle"}, 64'(m_valid), 64'd0);
    check({tag, " s_ready back"}, 64'(s_ready), 64'd1);
  endtask

  task automatic push4(input logic [W-1:0] v [4]);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[i]);
  endtask

  initial begin
    logic [W-1:0] v [4];
    logic [W-1:0] bv;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b0;
    tick();
    tick();
    check("rst s_ready", 64'(s_ready), 64'd0);
    check("rst m_valid", 64'(m_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst err_len", 64'(err_len), 64'd0);
    check("rst vec_out", 64'(vec_out), 64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    #1;
    check("post-rst s_ready", 64'(s_ready), 64'd1);

    // 1: round trip with launch latency
    err_pulses = 0;
    v = '{8'd5, 8'hFD, 8'd127, 8'h80};
    push4(v);
    send4(v, 4, 1'b1, 1'b0, "t1");
    check("t1 vec_out", 64'(vec_out), 64'h807F_FD05);
    check("t1 s_ready", 64'(s_ready), 64'd0);
    check("t1 busy", 64'(busy), 64'd1);
    for (int k = 0; k <= 2; k++) begin
      check("t1 m_valid early", 64'(m_valid), 64'd0);
      tick();
    end
    check("t1 m_valid rise", 64'(m_valid), 64'd1);
    drain(4, 1'b0, "t1");
    check("t1 err pulses", 64'(err_pulses), 64'd0);

    // 2: backpressure; s_valid held high during the stream must be ignored
    v = '{8'd11, 8'hEA, 8'd33, 8'hD4};
    push4(v);
    send4(v, 4, 1'b1, 1'b0, "t2");
    s_valid = 1'b1;
    s_data  = 8'hAA;
    drain(4, 1'b1, "t2");
    s_valid = 1'b0;
    check("t2 vec_out", 64'(vec_out), 64'hD421_EA0B);

    // 3: early s_last pads with zeros
    err_pulses = 0;
    v = '{8'd9, 8'd7, 8'd0, 8'd0};
    push4(v);
    send4(v, 2, 1'b1, 1'b1, "t3");
    check("t3 vec_out", 64'(vec_out), 64'h0000_0709);
    tick();
    check("t3 err one cycle", 64'(err_len), 64'd0);
    drain(4, 1'b0, "t3");
    check("t3 err pulses", 64'(err_pulses), 64'd1);

    // 4: missing s_last still launches
    v = '{8'd1, 8'd2, 8'd3, 8'd4};
    push4(v);
    send4(v, 4, 1'b0, 1'b1, "t4");
    check("t4 vec_out", 64'(vec_out), 64'h0403_0201);
    drain(4, 1'b0, "t4");

    // 5: reset after two output handshakes
    v = '{8'd50, 8'd60, 8'd70, 8'd80};
    send4(v, 4, 1'b1, 1'b0, "t5");
    for (int k = 0; k < 3; k++) tick();
    check("t5 m_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    tick();
    tick();
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("t5 m_valid", 64'(m_valid), 64'd0);
    check("t5 busy", 64'(busy), 64'd0);
    check("t5 vec_out", 64'(vec_out), 64'd0);
    check("t5 s_ready in rst", 64'(s_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("t5 s_ready", 64'(s_ready), 64'd1);
    tick();
    check("t5 no stale output", 64'(m_valid), 64'd0);
    v = '{8'hF6, 8'd20, 8'hE2, 8'd40};
    push4(v);
    send4(v, 4, 1'b1, 1'b0, "t5b");
    drain(4, 1'b0, "t5b");

    // 6: full-size instance, result is element-wise negation
    for (int i = 0; i < 64; i++) begin
      bv = W'($urandom_range(0, 254)) - 8'd127;
      exp_q.push_back(8'd0 - bv);
      b_s_valid = 1'b1;
      b_s_data  = bv;
      b_s_last  = (i == 63);
      check("t6 s_ready", 64'(b_s_ready), 64'd1);
      tick();
    end
    b_s_valid = 1'b0;
    b_s_last  = 1'b0;
    for (int k = 0; k < 20 && !b_m_valid; k++) tick();
    check("t6 m_valid", 64'(b_m_valid), 64'd1);
    b_m_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      check("t6 valid", 64'(b_m_valid), 64'd1);
      if (exp_q.size() == 0) begin
        check("t6 queue empty", 64'(exp_q.size()), 64'd1);
      end else begin
        check("t6 data", 64'(b_m_data), 64'(exp_q.pop_front()));
      end
      check("t6 last", 64'(b_m_last), 64'(k == 63));
      tick();
    end
    b_m_ready = 1'b0;
    check("t6 drained", 64'(b_m_valid), 64'd0);
    check("t6 s_ready", 64'(b_s_ready), 64'd1);
    check("t6 queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
